tbus_arbiter: RTL and testbench

Parametrised controller for a shared tristate bus. It arbitrates N_CH requesting channels with a round-robin policy and drives per-channel active-high tristate enables. At most one enable is ever asserted, and a programmable all-off turnaround gap separates any two driving windows. The block sits beside the bank of per-channel TBUF drivers: each `en[i]` feeds the EN pin of channel i's tristate buffer on the shared net. Registered burst and hold control replaces the fixed inverter-enable scheme.

---
 rtl/tbus_pkg.sv | 15 +
 rtl/tbus_arbiter_if.sv | 26 ++
 rtl/tbus_rr_pick.sv | 30 +++
 rtl/tbus_arbiter.sv | 112 +++++++++++
 tb/tb_tbus_arbiter.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/tbus_pkg.sv
// Shared types and width helper for the tristate-bus arbiter.
package tbus_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        TURN  = 2'd2
    } tbus_state_e;

    // Index width that never collapses to zero bits.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/tbus_arbiter_if.sv
// Request/enable bundle between the requesting channels and the bus arbiter.
interface tbus_arbiter_if
    import tbus_pkg::*;
#(
    parameter int unsigned N_CH     = 4,
    parameter int unsigned MAX_HOLD = 4
) ();

    logic [N_CH-1:0]                 req;
    logic [N_CH-1:0]                 last;
    logic [N_CH-1:0]                 en;
    logic [idx_w(N_CH)-1:0]          owner;
    logic                            busy;
    logic [idx_w(MAX_HOLD+1)-1:0]    beat_cnt;

    modport master (
        output req, last,
        input  en, owner, busy, beat_cnt
    );

    modport slave (
        input  req, last,
        output en, owner, busy, beat_cnt
    );

endinterface

// File: rtl/tbus_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module tbus_rr_pick
    import tbus_pkg::*;
#(
    parameter int unsigned N_CH = 4
) (
    input  logic [N_CH-1:0]        req,
    input  logic [idx_w(N_CH)-1:0] ptr,
    output logic                   valid,
    output logic [idx_w(N_CH)-1:0] idx
);

    localparam int unsigned IW = idx_w(N_CH);

    always_comb begin
        int unsigned c;
        valid = 1'b0;
        idx   = '0;
        c     = 0;
        for (int unsigned k = 0; k < N_CH; k++) begin
            c = 32'(ptr) + k;
            if (c >= N_CH) c = c - N_CH;
            if (!valid && req[IW'(c)]) begin
                valid = 1'b1;
                idx   = IW'(c);
            end
        end
    end

endmodule

// File: rtl/tbus_arbiter.sv
// Round-robin owner selection and one-hot tristate enables with a turnaround gap.
module tbus_arbiter
    import tbus_pkg::*;
#(
    parameter int unsigned N_CH       = 4,
    parameter int unsigned TURNAROUND = 1,
    parameter int unsigned MAX_HOLD   = 4
) (
    input  logic          clk,
    input  logic          rst,
    tbus_arbiter_if.slave bus
);

    localparam int unsigned IW = idx_w(N_CH);
    localparam int unsigned BW = idx_w(MAX_HOLD + 1);
    localparam int unsigned TW = idx_w(TURNAROUND);

    tbus_state_e     state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [N_CH-1:0] en_q, en_d;
    logic            busy_q, busy_d;
    logic [BW-1:0]   beat_q, beat_d;
    logic [TW-1:0]   turn_q, turn_d;

    logic            pick_valid;
    logic [IW-1:0]   pick_idx;
    logic            owner_req;
    logic            release_c;

    tbus_rr_pick #(.N_CH(N_CH)) u_pick (
        .req   (bus.req),
        .ptr   (ptr_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // A missing strobe, a marked last beat or a full hold all end the window.
    assign owner_req = bus.req[owner_q];
    assign release_c = !owner_req || bus.last[owner_q]
                       || ((32'(beat_q) + 1) == MAX_HOLD);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            en_q    <= '0;
            busy_q  <= 1'b0;
            beat_q  <= '0;
            turn_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
            beat_q  <= beat_d;
            turn_q  <= turn_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pick_valid) state_d = DRIVE;
            DRIVE:   if (release_c) state_d = TURN;
            TURN:    if (turn_q == '0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        en_d    = en_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        beat_d  = beat_q;
        turn_d  = turn_q;
        case (state_q)
            IDLE: begin
                en_d = '0;
                if (pick_valid) begin
                    owner_d = pick_idx;
                    en_d    = N_CH'(1) << pick_idx;
                    beat_d  = '0;
                end
            end
            DRIVE: begin
                if (owner_req) beat_d = beat_q + BW'(1);
                if (release_c) begin
                    en_d   = '0;
                    ptr_d  = (owner_q == IW'(N_CH - 1)) ? '0 : owner_q + IW'(1);
                    turn_d = TW'(TURNAROUND - 1);
                end
            end
            TURN: begin
                en_d = '0;
                if (turn_q != '0) turn_d = turn_q - TW'(1);
            end
            default: en_d = '0;
        endcase
        busy_d = |en_d;
    end

    assign bus.en       = en_q;
    assign bus.owner    = owner_q;
    assign bus.busy     = busy_q;
    assign bus.beat_cnt = beat_q;

    a_en_onehot0: assert property (@(posedge clk) $onehot0(en_q));

endmodule

// File: tb/tb_tbus_arbiter.sv
// Randomized scoreboard bench for tbus_arbiter at two parameter points.
module tb_tbus_arbiter;

    localparam int N_A = 4, T_A = 1, H_A = 4;
    localparam int N_B = 3, T_B = 3, H_B = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tbus_arbiter_if #(.N_CH(N_A), .MAX_HOLD(H_A)) bus_a ();
    tbus_arbiter_if #(.N_CH(N_B), .MAX_HOLD(H_B)) bus_b ();

    tbus_arbiter #(.N_CH(N_A), .TURNAROUND(T_A), .MAX_HOLD(H_A)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    tbus_arbiter #(.N_CH(N_B), .TURNAROUND(T_B), .MAX_HOLD(H_B)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    typedef struct { bit drv; int owner; int ptr; int beats; int gap; int len; } mdl_t;
    typedef struct { logic [3:0] en; int owner; bit busy; int beat; } exp_t;
    typedef struct { int owner; int beats; int len; } win_t;

    mdl_t m0, m1;
    exp_t eq0[$], eq1[$];
    win_t wq0[$], wq1[$];
    int   checks = 0;
    int   errors = 0;
    logic [3:0] prev_en [2] = '{4'b0, 4'b0};
    int   run_len [2] = '{0, 0};
    int   run_own [2] = '{0, 0};

    // Reference: bus is either held by an owner, cooling down for a number of cycles, or free.
    function automatic void step(inout mdl_t s, input logic [3:0] rq, input logic [3:0] ls,
                                 input bit r, input int n, input int ta, input int mh,
                                 output exp_t e, output bit done, output win_t w);
        done = 1'b0;
        w.owner = 0; w.beats = 0; w.len = 0;
        if (r) begin
            s.drv = 1'b0; s.owner = 0; s.ptr = 0; s.beats = 0; s.gap = 0; s.len = 0;
        end else if (s.drv) begin
            s.len++;
            if (rq[2'(s.owner)]) s.beats++;
            if (!rq[2'(s.owner)] || ls[2'(s.owner)] || s.beats == mh) begin
                s.drv = 1'b0;
                s.ptr = (s.owner + 1) % n;
                s.gap = ta;
                done = 1'b1;
                w.owner = s.owner; w.beats = s.beats; w.len = s.len;
            end
        end else if (s.gap > 0) begin
            s.gap--;
        end else begin
            for (int k = 0; k < n; k++) begin
                int c = (s.ptr + k) % n;
                if (rq[2'(c)]) begin
                    s.drv = 1'b1; s.owner = c; s.beats = 0; s.len = 0;
                    break;
                end
            end
        end
        e.en    = s.drv ? 4'(1 << s.owner) : 4'b0;
        e.owner = s.owner;
        e.busy  = s.drv;
        e.beat  = s.beats;
    endfunction

    task automatic cyc(input logic [3:0] rq, input logic [3:0] ls, input bit r);
        exp_t e;
        bit   done;
        win_t w;
        @(negedge clk);
        rst        = r;
        bus_a.req  = rq;
        bus_a.last = ls;
        bus_b.req  = rq[2:0];
        bus_b.last = ls[2:0];
        step(m0, rq, ls, r, N_A, T_A, H_A, e, done, w);
        eq0.push_back(e);
        if (done) wq0.push_back(w);
        step(m1, {1'b0, rq[2:0]}, {1'b0, ls[2:0]}, r, N_B, T_B, H_B, e, done, w);
        eq1.push_back(e);
        if (done) wq1.push_back(w);
    endtask

    task automatic mon(input int d, input logic [3:0] en, input int own, input logic busy, input int beat);
        exp_t e;
        win_t w;
        bit   have;
        checks++;
        if (!$onehot0(en)) begin
            errors++;
            $display("FAIL onehot0 dut%0d t=%0t en=%b", d, $time, en);
        end
        have = 1'b0;
        if (d == 0 && eq0.size() > 0) begin e = eq0.pop_front(); have = 1'b1; end
        if (d == 1 && eq1.size() > 0) begin e = eq1.pop_front(); have = 1'b1; end
        if (have) begin
            checks++;
            if (en !== e.en || own != e.owner || busy !== e.busy || beat != e.beat) begin
                errors++;
                $display("FAIL cycle dut%0d t=%0t got en=%b owner=%0d busy=%b beat=%0d exp en=%b owner=%0d busy=%b beat=%0d",
                         d, $time, en, own, busy, beat, e.en, e.owner, e.busy, e.beat);
            end
        end
        // A window that ends other than by reset must match the next modelled grant.
        if (prev_en[d] != 4'b0 && en == 4'b0 && !rst) begin
            checks++;
            have = 1'b0;
            if (d == 0 && wq0.size() > 0) begin w = wq0.pop_front(); have = 1'b1; end
            if (d == 1 && wq1.size() > 0) begin w = wq1.pop_front(); have = 1'b1; end
            if (!have) begin
                errors++;
                $display("FAIL window dut%0d t=%0t got owner=%0d len=%0d with no expected grant",
                         d, $time, run_own[d], run_len[d]);
            end else if (run_own[d] != w.owner || run_len[d] != w.len || beat != w.beats) begin
                errors++;
                $display("FAIL window dut%0d t=%0t got owner=%0d len=%0d beats=%0d exp owner=%0d len=%0d beats=%0d",
                         d, $time, run_own[d], run_len[d], beat, w.owner, w.len, w.beats);
            end
        end
        if (en != 4'b0) begin
            run_len[d] = (prev_en[d] == 4'b0) ? 1 : run_len[d] + 1;
            run_own[d] = own;
        end
        prev_en[d] = en;
    endtask

    always begin
        @(posedge clk);
        #1;
        mon(0, bus_a.en, int'(bus_a.owner), bus_a.busy, int'(bus_a.beat_cnt));
        mon(1, {1'b0, bus_b.en}, int'(bus_b.owner), bus_b.busy, int'(bus_b.beat_cnt));
    end

    initial begin
        logic [3:0] rq;
        logic [3:0] ls;
        bit         r;
        bus_a.req = '0; bus_a.last = '0;
        bus_b.req = '0; bus_b.last = '0;
        m0 = '{1'b0, 0, 0, 0, 0, 0};
        m1 = '{1'b0, 0, 0, 0, 0, 0};

        // Reset held with all channels requesting, then full contention.
        repeat (3)  cyc(4'hF, 4'h0, 1'b1);
        repeat (30) cyc(4'hF, 4'h0, 1'b0);
        repeat (8)  cyc(4'h0, 4'h0, 1'b0);

        // Three-beat burst on channel 2.
        repeat (3)  cyc(4'b0100, 4'h0, 1'b0);
        cyc(4'b0100, 4'b0100, 1'b0);
        repeat (4)  cyc(4'h0, 4'h0, 1'b0);

        // Channel 1 one-beat window, then 3 and 0 contend past the wrap.
        cyc(4'b0010, 4'h0, 1'b0);
        cyc(4'b0010, 4'b0010, 1'b0);
        repeat (16) cyc(4'b1001, 4'h0, 1'b0);
        repeat (8)  cyc(4'h0, 4'h0, 1'b0);

        // Early drop after two beats.
        repeat (3)  cyc(4'b0001, 4'h0, 1'b0);
        repeat (6)  cyc(4'h0, 4'h0, 1'b0);

        // Reset in the middle of a window.
        repeat (4)  cyc(4'hF, 4'h0, 1'b0);
        cyc(4'hF, 4'h0, 1'b1);
        repeat (10) cyc(4'hF, 4'h0, 1'b0);
        repeat (8)  cyc(4'h0, 4'h0, 1'b0);

        // last coinciding with the MAX_HOLD-th beat.
        repeat (4)  cyc(4'b0100, 4'h0, 1'b0);
        cyc(4'b0100, 4'b0100, 1'b0);
        repeat (6)  cyc(4'h0, 4'h0, 1'b0);

        // Random traffic with sticky requests, sparse last and rare resets.
        rq = 4'h0;
        for (int i = 0; i < 3000; i++) begin
            rq = rq ^ (4'($urandom) & 4'($urandom));
            if ($urandom_range(0, 15) == 0) rq = 4'hF;
            ls = 4'($urandom) & 4'($urandom);
            r  = ($urandom_range(0, 199) == 0);
            cyc(rq, ls, r);
        end
        repeat (12) cyc(4'h0, 4'h0, 1'b0);

        @(posedge clk);
        #2;
        checks++;
        if (eq0.size() != 0 || eq1.size() != 0 || wq0.size() != 0 || wq1.size() != 0) begin
            errors++;
            $display("FAIL drain got pending eq0=%0d eq1=%0d wq0=%0d wq1=%0d exp all 0",
                     eq0.size(), eq1.size(), wq0.size(), wq1.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
